// File: rtl/port_rr_prioritizer_if.sv
// Request and slot-bundle signals of port_rr_prioritizer. The slave modport is the
// prioritizer itself; the master modport is the upstream ports plus the downstream consumer.
interface port_rr_prioritizer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  port1_valid_in, port2_valid_in, port3_valid_in;
  logic                  port1_we_in,    port2_we_in,    port3_we_in;
  logic [ADDR_WIDTH-1:0] port1_addr_in,  port2_addr_in,  port3_addr_in;
  logic [DATA_WIDTH-1:0] port1_data_in,  port2_data_in,  port3_data_in;
  logic                  in_ready;

  // Handshake: a bundle moves downstream on any rising clk edge where out_valid && out_ready;
  // the three ports are taken together on any edge where in_ready is high.
  logic                  out_ready;
  logic                  out_valid;
  logic                  slot1_valid_out, slot2_valid_out, slot3_valid_out;
  logic                  slot1_we_out,    slot2_we_out,    slot3_we_out;
  logic [ADDR_WIDTH-1:0] slot1_addr_out,  slot2_addr_out,  slot3_addr_out;
  logic [DATA_WIDTH-1:0] slot1_data_out,  slot2_data_out,  slot3_data_out;
  logic [1:0]            slot1_orig_id,   slot2_orig_id,   slot3_orig_id;

  modport slave (
    input  port1_valid_in, port2_valid_in, port3_valid_in,
    input  port1_we_in, port2_we_in, port3_we_in,
    input  port1_addr_in, port2_addr_in, port3_addr_in,
    input  port1_data_in, port2_data_in, port3_data_in,
    input  out_ready,
    output in_ready, out_valid,
    output slot1_valid_out, slot2_valid_out, slot3_valid_out,
    output slot1_we_out, slot2_we_out, slot3_we_out,
    output slot1_addr_out, slot2_addr_out, slot3_addr_out,
    output slot1_data_out, slot2_data_out, slot3_data_out,
    output slot1_orig_id, slot2_orig_id, slot3_orig_id
  );

  modport master (
    output port1_valid_in, port2_valid_in, port3_valid_in,
    output port1_we_in, port2_we_in, port3_we_in,
    output port1_addr_in, port2_addr_in, port3_addr_in,
    output port1_data_in, port2_data_in, port3_data_in,
    output out_ready,
    input  in_ready, out_valid,
    input  slot1_valid_out, slot2_valid_out, slot3_valid_out,
    input  slot1_we_out, slot2_we_out, slot3_we_out,
    input  slot1_addr_out, slot2_addr_out, slot3_addr_out,
    input  slot1_data_out, slot2_data_out, slot3_data_out,
    input  slot1_orig_id, slot2_orig_id, slot3_orig_id
  );
endinterface

// File: rtl/port_rr_prioritizer.sv
// Packs three port requests into slots 1..3 (valid first, round-robin order) and tags each
// slot with its original port ID; one registered stage with valid/ready flow control.
module port_rr_prioritizer #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  port_rr_prioritizer_if.slave   bus,
  output logic [1:0]             dbg_ptr_o
);
  localparam logic [1:0] ORIG_PORT_1_ID = 2'd1;
  localparam logic [1:0] ORIG_PORT_2_ID = 2'd2;
  localparam logic [1:0] ORIG_PORT_3_ID = 2'd3;

  logic [2:0]            in_vld, in_we;
  logic [ADDR_WIDTH-1:0] in_addr [3];
  logic [DATA_WIDTH-1:0] in_data [3];

  logic                  out_valid_q;
  logic [1:0]            ptr_q, ptr_d, ptr_eff;
  logic [2:0]            slot_vld_q, slot_we_q;
  logic [ADDR_WIDTH-1:0] slot_addr_q [3];
  logic [DATA_WIDTH-1:0] slot_data_q [3];
  logic [1:0]            slot_id_q [3];
  logic [1:0]            order [3];
  logic                  load, any_vld;

  function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] orig_id(input logic [1:0] p);
    case (p)
      2'd0:    return ORIG_PORT_1_ID;
      2'd1:    return ORIG_PORT_2_ID;
      default: return ORIG_PORT_3_ID;
    endcase
  endfunction

  assign in_vld  = {bus.port3_valid_in, bus.port2_valid_in, bus.port1_valid_in};
  assign in_we   = {bus.port3_we_in, bus.port2_we_in, bus.port1_we_in};
  assign in_addr = '{bus.port1_addr_in, bus.port2_addr_in, bus.port3_addr_in};
  assign in_data = '{bus.port1_data_in, bus.port2_data_in, bus.port3_data_in};

  assign any_vld      = |in_vld;
  assign load         = !out_valid_q || bus.out_ready;
  assign bus.in_ready = load;
  // Pointer value 3 cannot be reached, but is folded onto port 1 if it ever appears.
  assign ptr_eff      = (ptr_q == 2'd3) ? 2'd0 : ptr_q;

  // Stable partition of the rotation order: valid ports first, then invalid ones.
  always_comb begin
    logic [1:0] n;
    logic [1:0] idx;
    order = '{2'd0, 2'd1, 2'd2};
    n     = 2'd0;
    idx   = 2'd0;
    for (int k = 0; k < 3; k++) begin
      idx = mod3_add(ptr_eff, 2'(k));
      if (in_vld[idx]) begin
        order[n] = idx;
        n        = n + 2'd1;
      end
    end
    for (int k = 0; k < 3; k++) begin
      idx = mod3_add(ptr_eff, 2'(k));
      if (!in_vld[idx]) begin
        order[n] = idx;
        n        = n + 2'd1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_eff;
    if (FIXED_PRIORITY) ptr_d = 2'd0;
    else if (load && any_vld) ptr_d = mod3_add(order[0], 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ptr_q       <= 2'd0;
      slot_vld_q  <= 3'b000;
      slot_we_q   <= 3'b000;
      slot_addr_q <= '{default: '0};
      slot_data_q <= '{default: '0};
      slot_id_q   <= '{ORIG_PORT_1_ID, ORIG_PORT_2_ID, ORIG_PORT_3_ID};
    end else begin
      ptr_q <= ptr_d;
      if (load) begin
        out_valid_q <= any_vld;
        for (int s = 0; s < 3; s++) begin
          slot_vld_q[s]  <= in_vld[order[s]];
          slot_we_q[s]   <= in_we[order[s]];
          slot_addr_q[s] <= in_addr[order[s]];
          slot_data_q[s] <= in_data[order[s]];
          slot_id_q[s]   <= orig_id(order[s]);
        end
      end
    end
  end

  assign bus.out_valid       = out_valid_q;
  assign bus.slot1_valid_out = slot_vld_q[0];
  assign bus.slot2_valid_out = slot_vld_q[1];
  assign bus.slot3_valid_out = slot_vld_q[2];
  assign bus.slot1_we_out    = slot_we_q[0];
  assign bus.slot2_we_out    = slot_we_q[1];
  assign bus.slot3_we_out    = slot_we_q[2];
  assign bus.slot1_addr_out  = slot_addr_q[0];
  assign bus.slot2_addr_out  = slot_addr_q[1];
  assign bus.slot3_addr_out  = slot_addr_q[2];
  assign bus.slot1_data_out  = slot_data_q[0];
  assign bus.slot2_data_out  = slot_data_q[1];
  assign bus.slot3_data_out  = slot_data_q[2];
  assign bus.slot1_orig_id   = slot_id_q[0];
  assign bus.slot2_orig_id   = slot_id_q[1];
  assign bus.slot3_orig_id   = slot_id_q[2];
  assign dbg_ptr_o           = ptr_q;
endmodule

// File: tb/tb_port_rr_prioritizer.sv
// Bench for port_rr_prioritizer: a round-robin instance checked cycle by cycle against a
// list-based ordering model, plus a fixed-priority instance.
module tb_port_rr_prioritizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] in_v, in_we;
  logic [3:0] in_a [3];
  logic [7:0] in_d [3];
  logic       out_ready;
  logic [1:0] rr_ptr, fp_ptr;

  port_rr_prioritizer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) rr_if ();
  port_rr_prioritizer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) fp_if ();

  assign rr_if.port1_valid_in = in_v[0];  assign fp_if.port1_valid_in = in_v[0];
  assign rr_if.port2_valid_in = in_v[1];  assign fp_if.port2_valid_in = in_v[1];
  assign rr_if.port3_valid_in = in_v[2];  assign fp_if.port3_valid_in = in_v[2];
  assign rr_if.port1_we_in    = in_we[0]; assign fp_if.port1_we_in    = in_we[0];
  assign rr_if.port2_we_in    = in_we[1]; assign fp_if.port2_we_in    = in_we[1];
  assign rr_if.port3_we_in    = in_we[2]; assign fp_if.port3_we_in    = in_we[2];
  assign rr_if.port1_addr_in  = in_a[0];  assign fp_if.port1_addr_in  = in_a[0];
  assign rr_if.port2_addr_in  = in_a[1];  assign fp_if.port2_addr_in  = in_a[1];
  assign rr_if.port3_addr_in  = in_a[2];  assign fp_if.port3_addr_in  = in_a[2];
  assign rr_if.port1_data_in  = in_d[0];  assign fp_if.port1_data_in  = in_d[0];
  assign rr_if.port2_data_in  = in_d[1];  assign fp_if.port2_data_in  = in_d[1];
  assign rr_if.port3_data_in  = in_d[2];  assign fp_if.port3_data_in  = in_d[2];
  assign rr_if.out_ready      = out_ready;
  assign fp_if.out_ready      = 1'b1;

  port_rr_prioritizer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FIXED_PRIORITY(1'b0)) u_rr (
    .clk(clk), .rst_n(rst_n), .bus(rr_if.slave), .dbg_ptr_o(rr_ptr));
  port_rr_prioritizer #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FIXED_PRIORITY(1'b1)) u_fp (
    .clk(clk), .rst_n(rst_n), .bus(fp_if.slave), .dbg_ptr_o(fp_ptr));

  // Per slot: {valid, we, addr[3:0], data[7:0], orig_id[1:0]}; slot 1 in the top 16 bits.
  wire [47:0] rr_bundle = {
    rr_if.slot1_valid_out, rr_if.slot1_we_out, rr_if.slot1_addr_out, rr_if.slot1_data_out, rr_if.slot1_orig_id,
    rr_if.slot2_valid_out, rr_if.slot2_we_out, rr_if.slot2_addr_out, rr_if.slot2_data_out, rr_if.slot2_orig_id,
    rr_if.slot3_valid_out, rr_if.slot3_we_out, rr_if.slot3_addr_out, rr_if.slot3_data_out, rr_if.slot3_orig_id};
  wire [47:0] fp_bundle = {
    fp_if.slot1_valid_out, fp_if.slot1_we_out, fp_if.slot1_addr_out, fp_if.slot1_data_out, fp_if.slot1_orig_id,
    fp_if.slot2_valid_out, fp_if.slot2_we_out, fp_if.slot2_addr_out, fp_if.slot2_data_out, fp_if.slot2_orig_id,
    fp_if.slot3_valid_out, fp_if.slot3_we_out, fp_if.slot3_addr_out, fp_if.slot3_data_out, fp_if.slot3_orig_id};
  wire [7:0] fp_dat [3] = '{fp_if.slot1_data_out, fp_if.slot2_data_out, fp_if.slot3_data_out};
  wire [1:0] fp_id  [3] = '{fp_if.slot1_orig_id, fp_if.slot2_orig_id, fp_if.slot3_orig_id};

  localparam logic [47:0] RESET_BUNDLE = 48'h0001_0002_0003;

  int          checks = 0;
  int          fails  = 0;
  logic [47:0] exp_q [$];
  int          m_ptr;
  logic        m_ov;
  logic [47:0] m_bundle;

  // Reference ordering: rotation list, valid ports kept first, invalid ones appended.
  function automatic logic [47:0] model_pack(input int p);
    int          ord [$];
    logic [47:0] r;
    ord = {};
    r   = '0;
    for (int k = 0; k < 3; k++) if (in_v[(p + k) % 3]) ord.push_back((p + k) % 3);
    for (int k = 0; k < 3; k++) if (!in_v[(p + k) % 3]) ord.push_back((p + k) % 3);
    foreach (ord[s]) r = {r[31:0], in_v[ord[s]], in_we[ord[s]], in_a[ord[s]], in_d[ord[s]], 2'(ord[s] + 1)};
    return r;
  endfunction

  function automatic int first_valid(input int p);
    for (int k = 0; k < 3; k++) if (in_v[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic reset_model();
    m_ov     = 1'b0;
    m_ptr    = 0;
    m_bundle = RESET_BUNDLE;
    exp_q.delete();
  endtask

  task automatic randomize_inputs(input logic [2:0] v);
    in_v = v;
    for (int i = 0; i < 3; i++) begin
      in_we[i] = 1'($urandom_range(0, 1));
      in_a[i]  = 4'($urandom_range(0, 15));
      in_d[i]  = 8'($urandom_range(0, 255));
    end
  endtask

  // One clock with the current inputs: checks in_ready, the bundle handed off, and the new state.
  task automatic tick(input string name);
    logic        exp_rdy;
    logic [47:0] exp_b;
    int          fv;
    #1;
    exp_rdy = !m_ov || out_ready;
    checks++;
    if (rr_if.in_ready !== exp_rdy) begin
      fails++; $display("FAIL %s in_ready: got %b want %b", name, rr_if.in_ready, exp_rdy);
    end
    if (m_ov && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++; $display("FAIL %s handoff: got %h with empty expected queue", name, rr_bundle);
      end else begin
        exp_b = exp_q.pop_front();
        if (rr_bundle !== exp_b) begin
          fails++; $display("FAIL %s handoff: got %h want %h", name, rr_bundle, exp_b);
        end
      end
    end
    if (exp_rdy) begin
      fv       = first_valid(m_ptr);
      m_bundle = model_pack(m_ptr);
      m_ov     = (in_v != 3'b000);
      if (fv >= 0) begin
        m_ptr = (fv + 1) % 3;
        exp_q.push_back(m_bundle);
      end
    end
    @(posedge clk); #1;
    checks += 3;
    if (rr_if.out_valid !== m_ov) begin
      fails++; $display("FAIL %s out_valid: got %b want %b", name, rr_if.out_valid, m_ov);
    end
    if (rr_bundle !== m_bundle) begin
      fails++; $display("FAIL %s bundle: got %h want %h", name, rr_bundle, m_bundle);
    end
    if (rr_ptr !== 2'(m_ptr)) begin
      fails++; $display("FAIL %s ptr: got %0d want %0d", name, rr_ptr, m_ptr);
    end
  endtask

  task automatic test_reset();
    randomize_inputs(3'b111);
    out_ready = 1'b1;
    reset_model();
    #23;
    checks += 6;
    if (rr_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b want 0", rr_if.out_valid); end
    if (rr_bundle !== RESET_BUNDLE) begin fails++; $display("FAIL reset bundle: got %h want %h", rr_bundle, RESET_BUNDLE); end
    if (rr_if.in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b want 1", rr_if.in_ready); end
    if (rr_ptr !== 2'd0) begin fails++; $display("FAIL reset ptr: got %0d want 0", rr_ptr); end
    if (fp_bundle !== RESET_BUNDLE) begin fails++; $display("FAIL reset fp_bundle: got %h want %h", fp_bundle, RESET_BUNDLE); end
    if (fp_if.out_valid !== 1'b0) begin fails++; $display("FAIL reset fp_out_valid: got %b want 0", fp_if.out_valid); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    logic [5:0] exp_ids [3];
    exp_ids = '{6'b01_10_11, 6'b10_11_01, 6'b11_01_10};
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      randomize_inputs(3'b111);
      tick("rotation");
      checks++;
      if ({rr_if.slot1_orig_id, rr_if.slot2_orig_id, rr_if.slot3_orig_id} !== exp_ids[c]) begin
        fails++;
        $display("FAIL rotation ids cycle %0d: got %b want %b", c,
                 {rr_if.slot1_orig_id, rr_if.slot2_orig_id, rr_if.slot3_orig_id}, exp_ids[c]);
      end
    end
  endtask

  task automatic test_port3_only();
    randomize_inputs(3'b100);
    in_d[2] = 8'hA5;
    tick("port3_only");
    checks += 4;
    if (rr_if.slot1_data_out !== 8'hA5) begin fails++; $display("FAIL port3 slot1_data: got %h want a5", rr_if.slot1_data_out); end
    if (rr_if.slot1_valid_out !== 1'b1) begin fails++; $display("FAIL port3 slot1_valid: got %b want 1", rr_if.slot1_valid_out); end
    if ({rr_if.slot1_orig_id, rr_if.slot2_orig_id, rr_if.slot3_orig_id} !== 6'b11_01_10) begin
      fails++; $display("FAIL port3 ids: got %b want 110110", {rr_if.slot1_orig_id, rr_if.slot2_orig_id, rr_if.slot3_orig_id});
    end
    if (rr_ptr !== 2'd0) begin fails++; $display("FAIL port3 ptr: got %0d want 0", rr_ptr); end
  endtask

  task automatic test_stall();
    logic [47:0] held;
    logic [1:0]  held_ptr;
    out_ready = 1'b1;
    randomize_inputs(3'($urandom_range(1, 7)));
    tick("stall_load");
    held     = rr_bundle;
    held_ptr = rr_ptr;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      randomize_inputs(3'($urandom_range(1, 7)));
      tick("stall_hold");
      checks++;
      if (rr_bundle !== held || rr_ptr !== held_ptr) begin
        fails++; $display("FAIL stall hold: got %h/%0d want %h/%0d", rr_bundle, rr_ptr, held, held_ptr);
      end
    end
    out_ready = 1'b1;
    tick("stall_release");
    randomize_inputs(3'($urandom_range(0, 7)));
    tick("stall_after");
  endtask

  task automatic test_random();
    logic loaded;
    loaded = 1'b1;
    for (int c = 0; c < 200; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (loaded) randomize_inputs(3'($urandom_range(0, 7)));
      loaded = !m_ov || out_ready;
      tick("random");
    end
  endtask

  task automatic test_fixed();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      randomize_inputs(3'b111);
      tick("fixed_rr");
      checks += 3;
      if ({fp_id[0], fp_id[1], fp_id[2]} !== 6'b01_10_11) begin
        fails++; $display("FAIL fixed ids: got %b want 011011", {fp_id[0], fp_id[1], fp_id[2]});
      end
      if (fp_bundle !== model_pack(0) || fp_ptr !== 2'd0) begin
        fails++; $display("FAIL fixed bundle: got %h/%0d want %h/0", fp_bundle, fp_ptr, model_pack(0));
      end
      if (fp_dat[fp_id[0] - 2'd1] !== in_d[fp_id[0] - 2'd1] || fp_dat[0] !== in_d[0]) begin
        fails++; $display("FAIL fixed restore: got %h want %h", fp_dat[0], in_d[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      randomize_inputs(3'b011);
      tick("prereset");
    end
    #3;
    rst_n = 1'b0;
    #1;
    reset_model();
    checks += 3;
    if (rr_if.out_valid !== 1'b0) begin fails++; $display("FAIL midreset out_valid: got %b want 0", rr_if.out_valid); end
    if (rr_bundle !== RESET_BUNDLE) begin fails++; $display("FAIL midreset bundle: got %h want %h", rr_bundle, RESET_BUNDLE); end
    if (rr_ptr !== 2'd0) begin fails++; $display("FAIL midreset ptr: got %0d want 0", rr_ptr); end
    @(negedge clk);
    rst_n = 1'b1;
    randomize_inputs(3'b011);
    tick("postreset");
    checks++;
    if (rr_if.slot1_orig_id !== 2'd1) begin
      fails++; $display("FAIL postreset slot1_orig_id: got %0d want 1", rr_if.slot1_orig_id);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_port3_only();
    test_stall();
    test_random();
    test_fixed();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
